// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM pipeline stage: instruction codes for
// loads/stores, FSM state encoding, data width and small decode helpers.
package mem_access_pkg;

    localparam int DATA_W = 32;

    localparam logic [7:0] OP_LB  = 8'h20;
    localparam logic [7:0] OP_LBU = 8'h21;
    localparam logic [7:0] OP_LH  = 8'h22;
    localparam logic [7:0] OP_LHU = 8'h23;
    localparam logic [7:0] OP_LW  = 8'h24;
    localparam logic [7:0] OP_SB  = 8'h28;
    localparam logic [7:0] OP_SH  = 8'h29;
    localparam logic [7:0] OP_SW  = 8'h2A;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic is_load(input logic [7:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_mem_op(input logic [7:0] op);
        return is_load(op) || is_store(op);
    endfunction

    // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] lo);
        if ((op == OP_LW) || (op == OP_SW))
            return lo != 2'b00;
        else if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH))
            return lo[0];
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Bundle of the pipeline-side and memory-side signals of the MEM stage.
// slave: the mem_access block; master: its environment (pipeline + memory).
interface mem_access_if;
    import mem_access_pkg::*;

    logic              in_valid;
    logic [7:0]        inst_name;
    logic [DATA_W-1:0] aluResult;
    logic [DATA_W-1:0] readData2;
    logic [4:0]        writeDataReg;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_err;
    logic [DATA_W-1:0] out_memData;
    logic [4:0]        out_writeDataReg;

    modport slave (
        input  in_valid, inst_name, aluResult, readData2, writeDataReg,
        input  mem_ack, mem_rdata,
        output stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output out_valid, out_err, out_memData, out_writeDataReg
    );

    modport master (
        output in_valid, inst_name, aluResult, readData2, writeDataReg,
        output mem_ack, mem_rdata,
        input  stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  out_valid, out_err, out_memData, out_writeDataReg
    );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: store byte enables / replicated write
// data, and load lane selection with sign or zero extension.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [7:0]        i_st_op,
    input  logic [1:0]        i_st_addr,
    input  logic [DATA_W-1:0] i_st_data,
    output logic [3:0]        o_be,
    output logic [DATA_W-1:0] o_wdata,
    input  logic [7:0]        i_ld_op,
    input  logic [1:0]        i_ld_addr,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_ld_data
);
    logic [7:0]  w_lane [4];
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_lane[gi] = i_rdata[8*gi +: 8];
    end

    // Halfword lane follows addr[1] only; a stray addr[0] is ignored.
    assign w_byte = w_lane[i_ld_addr];
    assign w_half = i_ld_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Store side: enables and data replicated across every candidate lane.
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = '0;
        case (i_st_op)
            OP_SB: begin
                o_be    = 4'b0001 << i_st_addr;
                o_wdata = {4{i_st_data[7:0]}};
            end
            OP_SH: begin
                o_be    = i_st_addr[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_st_data[15:0]}};
            end
            OP_SW: begin
                o_be    = 4'b1111;
                o_wdata = i_st_data;
            end
            default: ;
        endcase
    end

    // Load side: pick the lane then extend to full width.
    always_comb begin
        o_ld_data = i_rdata;
        case (i_ld_op)
            OP_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_ld_data = {24'd0, w_byte};
            OP_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_ld_data = {16'd0, w_half};
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: single outstanding load/store with a wait-timeout,
// single-cycle pass-through for everything else.
// Optional build macro MEM_ALIGN_CHECK_EN turns misaligned accesses into an
// immediate error result instead of a truncated-address memory access.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    mem_access_if.slave bus
);
    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

    state_e            r_state, w_state_next;
    logic [CNT_W-1:0]  r_wait_cnt, w_wait_cnt_next;
    logic [7:0]        r_op, w_op_next;
    logic [DATA_W-1:0] r_addr, w_addr_next;
    logic [4:0]        r_wdr, w_wdr_next;
    logic              r_mem_req, w_mem_req_next;
    logic              r_mem_we, w_mem_we_next;
    logic [DATA_W-1:0] r_mem_addr, w_mem_addr_next;
    logic [3:0]        r_mem_be, w_mem_be_next;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_next;
    logic              r_out_valid, w_out_valid_next;
    logic              r_out_err, w_out_err_next;
    logic [DATA_W-1:0] r_out_data, w_out_data_next;
    logic [4:0]        r_out_wdr, w_out_wdr_next;
    logic              w_stall;
    logic              w_misaligned;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_ld_data;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misaligned = is_misaligned(bus.inst_name, bus.aluResult[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    // Store steering uses the live request; load extraction uses the captured op.
    mem_lane_align u_lane_align (
        .i_st_op   (bus.inst_name),
        .i_st_addr (bus.aluResult[1:0]),
        .i_st_data (bus.readData2),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .i_ld_op   (r_op),
        .i_ld_addr (r_addr[1:0]),
        .i_rdata   (bus.mem_rdata),
        .o_ld_data (w_ld_data)
    );

    // Next-state and next-output decode; stall is the only combinational output.
    always_comb begin
        w_state_next     = r_state;
        w_wait_cnt_next  = r_wait_cnt;
        w_op_next        = r_op;
        w_addr_next      = r_addr;
        w_wdr_next       = r_wdr;
        w_mem_req_next   = r_mem_req;
        w_mem_we_next    = r_mem_we;
        w_mem_addr_next  = r_mem_addr;
        w_mem_be_next    = r_mem_be;
        w_mem_wdata_next = r_mem_wdata;
        w_out_valid_next = 1'b0;
        w_out_err_next   = 1'b0;
        w_out_data_next  = r_out_data;
        w_out_wdr_next   = r_out_wdr;
        w_stall          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (w_misaligned) begin
                        w_out_valid_next = 1'b1;
                        w_out_err_next   = 1'b1;
                        w_out_data_next  = bus.aluResult;
                        w_out_wdr_next   = 5'd0;
                    end else if (is_mem_op(bus.inst_name)) begin
                        w_stall          = 1'b1;
                        w_state_next     = S_REQ;
                        w_wait_cnt_next  = '0;
                        w_op_next        = bus.inst_name;
                        w_addr_next      = bus.aluResult;
                        w_wdr_next       = bus.writeDataReg;
                        w_mem_req_next   = 1'b1;
                        w_mem_we_next    = is_store(bus.inst_name);
                        w_mem_addr_next  = {bus.aluResult[DATA_W-1:2], 2'b00};
                        w_mem_be_next    = w_be;
                        w_mem_wdata_next = w_wdata;
                    end else begin
                        w_out_valid_next = 1'b1;
                        w_out_data_next  = bus.aluResult;
                        w_out_wdr_next   = bus.writeDataReg;
                    end
                end
            end
            S_REQ: begin
                w_stall = 1'b1;
                if (bus.mem_ack) begin
                    w_state_next     = S_DONE;
                    w_mem_req_next   = 1'b0;
                    w_mem_we_next    = 1'b0;
                    w_out_valid_next = 1'b1;
                    w_out_data_next  = is_load(r_op) ? w_ld_data : r_addr;
                    w_out_wdr_next   = r_wdr;
                end else if (r_wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                    w_state_next     = S_DONE;
                    w_mem_req_next   = 1'b0;
                    w_mem_we_next    = 1'b0;
                    w_out_valid_next = 1'b1;
                    w_out_err_next   = 1'b1;
                    w_out_data_next  = '0;
                    w_out_wdr_next   = 5'd0;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= '0;
            r_op        <= '0;
            r_addr      <= '0;
            r_wdr       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_out_data  <= '0;
            r_out_wdr   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_wait_cnt  <= w_wait_cnt_next;
            r_op        <= w_op_next;
            r_addr      <= w_addr_next;
            r_wdr       <= w_wdr_next;
            r_mem_req   <= w_mem_req_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_be    <= w_mem_be_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_out_valid <= w_out_valid_next;
            r_out_err   <= w_out_err_next;
            r_out_data  <= w_out_data_next;
            r_out_wdr   <= w_out_wdr_next;
        end
    end

    assign bus.stall            = w_stall && !rst;
    assign bus.mem_req          = r_mem_req;
    assign bus.mem_we           = r_mem_we;
    assign bus.mem_addr         = r_mem_addr;
    assign bus.mem_be           = r_mem_be;
    assign bus.mem_wdata        = r_mem_wdata;
    assign bus.out_valid        = r_out_valid;
    assign bus.out_err          = r_out_err;
    assign bus.out_memData      = r_out_data;
    assign bus.out_writeDataReg = r_out_wdr;
endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: fixed vector table, hand-written
// reset / pass-through / alignment sequences and randomized transactions
// against a transaction-level reference model.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int MW = 4;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    mem_access_if bus();

    mem_access #(.MAX_WAIT(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [4:0]  wdr;
        int          ack;
        bit          mem;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one instruction and follow it to completion; ends in IDLE at a negedge.
    task automatic run_txn(input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [31:0] rdata,
                           input logic [4:0] wdr, input int ack, input bit mem_path,
                           input logic [3:0] e_be, input logic e_we,
                           input logic [31:0] e_wdata, input logic [31:0] e_data,
                           input logic e_err);
        int n_req;
        n_req = (ack >= 1 && ack <= MW) ? ack : MW;
        $display("txn op=%h addr=%h sdata=%h rdata=%h ack=%0d mem=%0d",
                 op, addr, sdata, rdata, ack, mem_path);
        bus.in_valid     = 1'b1;
        bus.inst_name    = op;
        bus.aluResult    = addr;
        bus.readData2    = sdata;
        bus.writeDataReg = wdr;
        bus.mem_rdata    = rdata;
        bus.mem_ack      = 1'b0;
        #1;
        chk("stall_accept", bus.stall, mem_path);
        @(negedge clk);
        if (mem_path) begin
            for (int k = 1; k <= n_req; k++) begin
                chk("req_mem_req", bus.mem_req, 1);
                chk("req_stall", bus.stall, 1);
                chk("req_out_valid", bus.out_valid, 0);
                chk("req_addr", bus.mem_addr, {addr[31:2], 2'b00});
                chk("req_be", bus.mem_be, e_be);
                chk("req_we", bus.mem_we, e_we);
                if (e_we) chk("req_wdata", bus.mem_wdata, e_wdata);
                if (k == ack) bus.mem_ack = 1'b1;
                @(negedge clk);
                bus.mem_ack = 1'b0;
            end
            chk("done_mem_req", bus.mem_req, 0);
            chk("done_stall", bus.stall, 0);
        end else begin
            chk("pass_mem_req", bus.mem_req, 0);
        end
        chk("out_valid", bus.out_valid, 1);
        chk("out_err", bus.out_err, e_err);
        chk("out_wdr", bus.out_writeDataReg, e_err ? 5'd0 : wdr);
        if (!e_err) chk("out_data", bus.out_memData, e_data);
        bus.in_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        @(negedge clk);
        chk("idle_out_valid", bus.out_valid, 0);
        chk("idle_stall", bus.stall, 0);
    endtask

    // Reference model: expected result of one instruction from the lane rules.
    task automatic model_run(input logic [7:0] op, input logic [31:0] addr,
                             input logic [31:0] sdata, input logic [31:0] rdata,
                             input logic [4:0] wdr, input int ack);
        int unsigned off;
        bit ld, st, mis, timed_out;
        logic [7:0]  b;
        logic [15:0] h;
        logic [3:0]  be;
        logic [31:0] wd, data;
        off = addr[1:0];
        ld  = (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
        st  = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        mis = ALIGN_EN && ((((op == OP_LW) || (op == OP_SW)) && off != 0) ||
                           (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && (off % 2) == 1));
        if (!(ld || st) || mis) begin
            run_txn(op, addr, sdata, rdata, wdr, ack, 1'b0, 4'h0, 1'b0, 32'h0, addr, mis);
        end else begin
            b  = 8'((rdata >> (8 * off)) & 32'hFF);
            h  = 16'((rdata >> (16 * (off / 2))) & 32'hFFFF);
            be = 4'hF;
            wd = 32'h0;
            data = addr;
            if (op == OP_SB) begin be = 4'(1 << off); wd = sdata[7:0] * 32'h0101_0101; end
            if (op == OP_SH) begin be = (off >= 2) ? 4'hC : 4'h3; wd = sdata[15:0] * 32'h0001_0001; end
            if (op == OP_SW) wd = sdata;
            if (op == OP_LB)  data = {{24{b[7]}}, b};
            if (op == OP_LBU) data = {24'd0, b};
            if (op == OP_LH)  data = {{16{h[15]}}, h};
            if (op == OP_LHU) data = {16'd0, h};
            if (op == OP_LW)  data = rdata;
            timed_out = !(ack >= 1 && ack <= MW);
            run_txn(op, addr, sdata, rdata, wdr, ack, 1'b1, be, st, wd, data, timed_out);
        end
    endtask

    logic [7:0] rand_ops [10];

    initial begin
        tbl[0]  = '{OP_LW,  32'h0000_1004, 32'h0,          32'hDEAD_BEEF, 5'd5,  3, 1'b1, 4'hF, 1'b0, 32'h0,          32'hDEAD_BEEF, 1'b0};
        tbl[1]  = '{OP_SB,  32'h0000_1003, 32'h0000_00A5, 32'h0,          5'd6,  1, 1'b1, 4'h8, 1'b1, 32'hA5A5_A5A5, 32'h0000_1003, 1'b0};
        tbl[2]  = '{OP_LB,  32'h0000_1002, 32'h0,          32'h0080_0000, 5'd7,  2, 1'b1, 4'hF, 1'b0, 32'h0,          32'hFFFF_FF80, 1'b0};
        tbl[3]  = '{OP_LBU, 32'h0000_1002, 32'h0,          32'h0080_0000, 5'd8,  1, 1'b1, 4'hF, 1'b0, 32'h0,          32'h0000_0080, 1'b0};
        tbl[4]  = '{OP_LH,  32'h0000_2002, 32'h0,          32'h8001_7FFF, 5'd9,  1, 1'b1, 4'hF, 1'b0, 32'h0,          32'hFFFF_8001, 1'b0};
        tbl[5]  = '{OP_LHU, 32'h0000_2000, 32'h0,          32'h8001_F00D, 5'd10, 3, 1'b1, 4'hF, 1'b0, 32'h0,          32'h0000_F00D, 1'b0};
        tbl[6]  = '{OP_SH,  32'h0000_3002, 32'h1234_BEEF, 32'h0,          5'd11, 2, 1'b1, 4'hC, 1'b1, 32'hBEEF_BEEF, 32'h0000_3002, 1'b0};
        tbl[7]  = '{OP_SW,  32'h0000_4000, 32'hCAFE_F00D, 32'h0,          5'd12, 4, 1'b1, 4'hF, 1'b1, 32'hCAFE_F00D, 32'h0000_4000, 1'b0};
        tbl[8]  = '{OP_LW,  32'h0000_5000, 32'h0,          32'h1111_2222, 5'd13, 0, 1'b1, 4'hF, 1'b0, 32'h0,          32'h0,          1'b1};
        tbl[9]  = '{8'h01,  32'h1234_5678, 32'h0,          32'h0,          5'd14, 0, 1'b0, 4'h0, 1'b0, 32'h0,          32'h1234_5678, 1'b0};
        tbl[10] = '{OP_LB,  32'h0000_1001, 32'h0,          32'h0000_7F00, 5'd15, 1, 1'b1, 4'hF, 1'b0, 32'h0,          32'h0000_007F, 1'b0};
        tbl[11] = '{OP_SB,  32'h0000_2000, 32'h1122_3344, 32'h0,          5'd16, 1, 1'b1, 4'h1, 1'b1, 32'h4444_4444, 32'h0000_2000, 1'b0};
        rand_ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW, 8'h01, 8'h33};

        // Reset with a load presented: nothing may leak out, stall held low.
        rst              = 1'b1;
        bus.in_valid     = 1'b1;
        bus.inst_name    = OP_LW;
        bus.aluResult    = 32'h0000_1004;
        bus.readData2    = 32'hFFFF_FFFF;
        bus.writeDataReg = 5'd3;
        bus.mem_ack      = 1'b1;
        bus.mem_rdata    = 32'hFFFF_FFFF;
        #1;
        chk("rst_stall_comb", bus.stall, 0);
        repeat (2) @(negedge clk);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_be", bus.mem_be, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_err", bus.out_err, 0);
        chk("rst_out_data", bus.out_memData, 0);
        chk("rst_out_wdr", bus.out_writeDataReg, 0);
        chk("rst_stall", bus.stall, 0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        @(negedge clk);

        // Stray ack while idle must not produce anything.
        bus.mem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_ack_out_valid", bus.out_valid, 0);
        chk("idle_ack_mem_req", bus.mem_req, 0);
        bus.mem_ack = 1'b0;

        // Fixed vector table.
        for (int i = 0; i < 12; i++)
            run_txn(tbl[i].op, tbl[i].addr, tbl[i].sdata, tbl[i].rdata, tbl[i].wdr,
                    tbl[i].ack, tbl[i].mem, tbl[i].be, tbl[i].we, tbl[i].wdata,
                    tbl[i].data, tbl[i].err);

        // Back-to-back pass-through ops, one result per cycle.
        $display("txn back-to-back pass-through");
        bus.in_valid = 1'b1; bus.inst_name = 8'h01; bus.aluResult = 32'hAAAA_0001; bus.writeDataReg = 5'd1;
        @(negedge clk);
        chk("b2b_valid0", bus.out_valid, 1);
        chk("b2b_data0", bus.out_memData, 32'hAAAA_0001);
        bus.inst_name = 8'h33; bus.aluResult = 32'hBBBB_0002; bus.writeDataReg = 5'd2;
        #1;
        chk("b2b_stall", bus.stall, 0);
        @(negedge clk);
        chk("b2b_valid1", bus.out_valid, 1);
        chk("b2b_data1", bus.out_memData, 32'hBBBB_0002);
        chk("b2b_wdr1", bus.out_writeDataReg, 5'd2);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_idle", bus.out_valid, 0);

        // Reset in the middle of a request; a late ack afterwards is ignored.
        $display("txn reset during REQ");
        bus.in_valid = 1'b1; bus.inst_name = OP_LW; bus.aluResult = 32'h0000_6000; bus.writeDataReg = 5'd4;
        @(negedge clk);
        chk("rreq_mem_req", bus.mem_req, 1);
        @(negedge clk);
        rst = 1'b1; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rreq_mem_req_cleared", bus.mem_req, 0);
        chk("rreq_addr_cleared", bus.mem_addr, 0);
        rst = 1'b0; bus.mem_ack = 1'b1;
        #1;
        chk("rreq_stall_after", bus.stall, 0);
        @(negedge clk);
        chk("rreq_late_ack_valid", bus.out_valid, 0);
        chk("rreq_late_ack_req", bus.mem_req, 0);
        bus.mem_ack = 1'b0;
        @(negedge clk);

        // Misaligned word load: error (check build) or lane-0 access at 0x1000.
        model_run(OP_LW, 32'h0000_1002, 32'h0, 32'h0BAD_CAFE, 5'd20, 2);

        // Randomized transactions against the reference model.
        for (int i = 0; i < 40; i++)
            model_run(rand_ops[$urandom_range(9, 0)], $urandom, $urandom, $urandom,
                      5'($urandom_range(31, 0)), int'($urandom_range(6, 0)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter MAX_WAIT, default 16, cycles a memory request may wait for mem_ack before timing out.
REQ-002 clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  the EX/MEM register holds a valid instruction.
REQ-005 inst_name  input  8  decoded instruction code; load/store codes come from the shared package.
REQ-006 aluResult  input  32  effective byte address for loads/stores; pass-through result otherwise.
REQ-007 readData2  input  32  store data.
REQ-008 writeDataReg  input  5  destination register number.
REQ-009 stall  output  1  the upstream pipeline must hold its inputs.
REQ-010 mem_req, mem_we  output  1 each  memory request and write strobe.
REQ-011 mem_addr  output  32  word-aligned address, with bits [1:0] = 00.
REQ-012 mem_be  output  4  byte enables; bit i enables byte lane [8i+7:8i].
REQ-013 mem_wdata  output  32  lane-aligned store data.
REQ-014 mem_ack  input  1  memory completed the request; mem_rdata is valid in the same cycle.
REQ-015 mem_rdata  input  32  read data word.
REQ-016 out_valid, out_err  output  1 each  result valid to MEM/WB; error marker.
REQ-017 out_memData  output  32  load data, or pass-through of aluResult.
REQ-018 out_writeDataReg  output  5  destination register; forced to 0 when out_err=1.

Function
REQ-019 FSM states: IDLE, REQ, DONE. All outputs except stall are registered.
REQ-020 IDLE, in_valid, non-memory op: the next edge produces out_valid=1, out_memData=aluResult, and out_writeDataReg=writeDataReg. There is no stall; latency is 1.
REQ-021 IDLE, in_valid, load/store op: stall=1 combinationally in the same cycle. The next edge enters REQ, sets mem_req=1, and drives mem_addr/mem_we/mem_be/mem_wdata. The operation and address are captured internally.
REQ-022 REQ: mem_req, address, be and wdata hold stable until mem_ack. stall=1 throughout.
REQ-023 REQ with mem_ack=1: at that edge, mem_req goes to 0, load data is captured, and the FSM enters DONE. An ack in the first REQ cycle is legal.
REQ-024 DONE: out_valid=1 for exactly one cycle and stall=0, then the FSM returns to IDLE. A new in_valid in DONE is not accepted until IDLE.
REQ-025 The wait counter clears on entry to REQ. Once it reaches MAX_WAIT without mem_ack, the FSM drops mem_req, enters DONE with out_err=1, and forces out_writeDataReg=0.
REQ-026 mem_ack outside REQ is ignored.
REQ-027 Byte lanes are little-endian:
- SB: be = 1<<addr[1:0]; wdata is the byte replicated four times.
- SH: be = addr[1] ? 1100 : 0011; wdata is the halfword replicated twice.
- SW: be = 1111.
- Loads: be = 1111 and mem_we = 0.
REQ-028 Loads select the addressed lane. LB and LH sign-extend; LBU and LHU zero-extend; LW takes the full word.
REQ-029 When not in DONE, out_valid = 0 except on the single-cycle pass-through of REQ-020.

Reset
REQ-030 rst at any edge, including mid-REQ, returns the FSM to IDLE. It also clears mem_req, mem_we, mem_be, mem_addr, mem_wdata, out_valid, out_err, out_memData, out_writeDataReg and the wait counter to 0.
REQ-031 stall is 0 during reset.

Configuration
REQ-032 Macro MEM_ALIGN_CHECK_EN is defined:
- A misaligned access (LW/SW with addr[1:0] != 00, or LH/LHU/SH with addr[0] = 1) issues no memory request.
- The next edge gives out_valid=1, out_err=1 and out_writeDataReg=0; latency is 1.
REQ-033 MEM_ALIGN_CHECK_EN is undefined:
- No alignment check is made.
- The offending low address bits are ignored: word accesses use lane 0, and halfword accesses use addr[1].

Structure
REQ-034 The shared package holds:
- inst_name codes for LB, LBU, LH, LHU, LW, SB, SH, SW;
- the FSM state enumeration;
- the data-width constant.
REQ-035 One sub-module, mem_lane_align, holds the combinational be/wdata generation and load extraction/extension.

Verification
REQ-036 LW, addr 0x0000_1004, mem_rdata 0xDEAD_BEEF, ack on the 3rd REQ cycle:
- Responses: mem_addr=0x1004, be=1111, stall high 4 cycles, then out_memData=0xDEAD_BEEF and out_valid for 1 cycle.
REQ-037 SB, addr 0x1003, data 0x0000_00A5, ack in the 1st cycle:
- Responses: be=1000, mem_we=1, wdata=0xA5A5_A5A5.
REQ-038 LB/LBU, addr 0x1002, rdata 0x0080_0000:
- Responses: LB gives 0xFFFF_FF80; LBU gives 0x0000_0080.
REQ-039 No ack, MAX_WAIT=4:
- Responses: mem_req drops after 4 cycles; out_err=1, out_writeDataReg=0.
REQ-040 rst asserted in REQ:
- Responses: mem_req=0 and state IDLE next edge; a late mem_ack is ignored.
REQ-041 With MEM_ALIGN_CHECK_EN, LW at 0x1002:
- Responses: no mem_req; out_err=1 after 1 cycle.
- Without the macro: mem_addr=0x1000 and normal completion.
